cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter UC_DEPTH, default 256: number of microcode words.
REQ-002 Parameter UC_WIDTH, default 24: microword width in bits.
REQ-003 Port clock  input  1: the only clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-low reset.
REQ-005 Port data_in  input  32 [0:31]: memory read data, valid combinationally in the same cycle as address.
REQ-006 Port address  output  17 [15:31]: memory word address; the block only reads memory and has no write port.
REQ-007 Internal signals o (7-bit opcode register) and ende (1-bit end-of-instruction strobe) SHALL exist under exactly these names for hierarchical probing.

Function
REQ-008 Datapath registers: P 17-bit program counter, C 32-bit, A 32-bit, O 7-bit, R 4-bit, CC 4-bit, uPC 8-bit, and a 16x32 register file RF.
REQ-009 The microinstruction is the combinational read of uc_rom memory[uPC]; each microword executes in one clock.
REQ-010 Microword fields (bit 23 = MSB): [23:22] seq, [21:20] cond, [19] addr_sel, [18] ld_c, [17] ld_or, [16] p_inc, [15] p_ld, [14:12] a_op, [11] rf_wr, [10] cc_ld, [9] ende, [8] reserved (ignored), [7:0] addr.
REQ-011 address = P when addr_sel=0; address = C[15:31] when addr_sel=1.
REQ-012 seq: 0 -> uPC+1; 1 -> addr; 2 -> {1'b1, O} (opcode dispatch into 0x80-0xFF); 3 -> addr if cond true, else uPC+1; uPC wraps modulo 256.
REQ-013 cond: 0 -> A==0; 1 -> A[0] (sign); 2 -> CC[0] (carry); 3 -> always true.
REQ-014 ld_c: C <= data_in.
REQ-015 ld_or: O <= C[1:7], R <= C[8:11], using the pre-edge value of C.
REQ-016 p_ld: P <= C[15:31]; else p_inc: P <= P+1, wrapping at 2^17; p_ld has priority when both are set.
REQ-017 a_op: 0 hold; 1 RF[R]; 2 C; 3 A+C; 4 A-C; 5 A&C; 6 A|C; 7 A^C. All operands are pre-edge values.
REQ-018 cc_ld: CC[0] <= carry out of the a_op 3 or 4 result (borrow inverted for subtraction, i.e. carry = no borrow), else 0; CC[1] <= 0; CC[2] <= new A > 0 signed; CC[3] <= new A < 0 signed.
REQ-019 rf_wr: RF[R] <= pre-edge A, with the pre-edge R selecting the register; R0 is an ordinary register.
REQ-020 ende equals the current microword's ende bit, combinationally; one high cycle marks one completed instruction.
REQ-021 Opcode 0x2E (46) is WAIT: microcode holds in a self-loop, and o stays 46 until reset.

Reset
REQ-022 When reset is low at a rising edge: uPC, P, A, C, O, R and CC SHALL be 0; RF and uc_rom contents are not reset.
REQ-023 Reset dominates all microword actions on that edge; after reset address = 0, provided memory[0] has addr_sel=0.
REQ-024 Reset asserted mid-instruction abandons the instruction; no RF write occurs on the reset edge.

Structure
REQ-025 Microword field positions, seq/cond/a_op encodings and the WAIT opcode constant (46) SHALL live in a shared package cpu_pkg.
REQ-026 Sub-module uc_rom SHALL be instance name uc_rom holding array memory[0:UC_DEPTH-1] of UC_WIDTH bits, with an asynchronous read and contents loaded by $readmemh.

Verification
REQ-027 The bench supplies memory with an asynchronous read, loads uc_rom from a hex file and programs from a hex file, and runs at 10 MHz.
REQ-028 Scenario 1: reset low for 1 cycle, then high -> address=0, uPC=0, o=0 on the first cycle after reset.
REQ-029 Scenario 2: fetch microcode (ld_c, p_inc, then ld_or, then dispatch) with memory[0]=0x2E000000 -> o==46 within 4 cycles, and uPC enters the 0xAE loop.
REQ-030 Scenario 3: RF[1]=5, C=0xFFFFFFFB, a_op=1 then a_op=3 with cc_ld -> A=0, CC=4'b1000.
REQ-031 Scenario 4: A=1, C=2, a_op=4 with cc_ld -> A=0xFFFFFFFF, CC=4'b0001, and cond 1 jump taken.
REQ-032 Scenario 5: P=0x1FFFF with p_inc -> P=0; with p_inc and p_ld, C[15:31]=0x40 -> P=0x40.
REQ-033 Scenario 6: three-instruction program ending in WAIT -> the ende count is 3 before o==46; reset asserted mid-run -> restart from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared microword layout and field encodings for the microcoded cpu.
package cpu_pkg;

    typedef enum logic [1:0] {
        SEQ_NEXT     = 2'd0,
        SEQ_JUMP     = 2'd1,
        SEQ_DISPATCH = 2'd2,
        SEQ_COND     = 2'd3
    } seq_e;

    typedef enum logic [1:0] {
        COND_ZERO   = 2'd0,
        COND_SIGN   = 2'd1,
        COND_CARRY  = 2'd2,
        COND_ALWAYS = 2'd3
    } cond_e;

    typedef enum logic [2:0] {
        AOP_HOLD = 3'd0,
        AOP_RF   = 3'd1,
        AOP_C    = 3'd2,
        AOP_ADD  = 3'd3,
        AOP_SUB  = 3'd4,
        AOP_AND  = 3'd5,
        AOP_OR   = 3'd6,
        AOP_XOR  = 3'd7
    } aop_e;

    // Opcodes with a fixed meaning to the microcode.
    typedef enum logic [6:0] {
        OP_WAIT = 7'd46
    } opcode_e;

    localparam int unsigned UW_BITS = 24;

    // Field order fixes bit positions: seq occupies [23:22], addr occupies [7:0].
    typedef struct packed {
        seq_e        seq;
        cond_e       cond;
        logic        addr_sel;
        logic        ld_c;
        logic        ld_or;
        logic        p_inc;
        logic        p_ld;
        aop_e        a_op;
        logic        rf_wr;
        logic        cc_ld;
        logic        ende;
        logic        rsvd;
        logic [7:0]  addr;
    } uword_t;

endpackage

// File: rtl/cpu_uc_rom.sv
// Microcode store: asynchronous-read array, contents supplied externally.
module cpu_uc_rom #(
    parameter int unsigned UC_DEPTH = 256,
    parameter int unsigned UC_WIDTH = 24,
    parameter int unsigned AW       = $clog2(UC_DEPTH)
) (
    input  logic [AW-1:0]       addr,
    output logic [UC_WIDTH-1:0] word
);

    logic [UC_WIDTH-1:0] memory [0:UC_DEPTH-1];

    assign word = memory[addr];

endmodule

// File: rtl/cpu.sv
// Microcoded cpu: one microword per clock, read-only memory interface.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned UC_DEPTH = 256,
    parameter int unsigned UC_WIDTH = 24
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [0:31]  data_in,
    output logic [15:31] address
);

    localparam int unsigned ROM_AW = $clog2(UC_DEPTH);

    logic [15:31]        p;
    logic [0:31]         c;
    logic [0:31]         a;
    logic [6:0]          o;
    logic [0:3]          r;
    logic [0:3]          cc;
    logic [7:0]          upc;
    logic [0:31]         rf [0:15];

    logic [UC_WIDTH-1:0] uc_word;
    uword_t              uw;
    logic                ende;
    logic                unused_rsvd;

    logic [0:31]         a_next;
    logic [32:0]         sum33;
    logic                carry;
    logic [0:3]          cc_next;
    logic                cond_true;
    logic [7:0]          upc_next;

    cpu_uc_rom #(
        .UC_DEPTH(UC_DEPTH),
        .UC_WIDTH(UC_WIDTH),
        .AW      (ROM_AW)
    ) uc_rom (
        .addr(upc[ROM_AW-1:0]),
        .word(uc_word)
    );

    assign uw          = uword_t'(uc_word[UW_BITS-1:0]);
    assign ende        = uw.ende;
    assign unused_rsvd = uw.rsvd;
    assign address     = uw.addr_sel ? c[15:31] : p;

    always_comb begin
        a_next = a;
        sum33  = '0;
        carry  = 1'b0;
        case (uw.a_op)
            AOP_HOLD: a_next = a;
            AOP_RF:   a_next = rf[r];
            AOP_C:    a_next = c;
            AOP_ADD: begin
                sum33  = {1'b0, a} + {1'b0, c};
                a_next = sum33[31:0];
                carry  = sum33[32];
            end
            AOP_SUB: begin
                // bit 32 is the borrow; carry reports "no borrow"
                sum33  = {1'b0, a} - {1'b0, c};
                a_next = sum33[31:0];
                carry  = ~sum33[32];
            end
            AOP_AND:  a_next = a & c;
            AOP_OR:   a_next = a | c;
            AOP_XOR:  a_next = a ^ c;
            default:  a_next = a;
        endcase
        cc_next = {carry, 1'b0, (~a_next[0] && (a_next != '0)), a_next[0]};
    end

    always_comb begin
        cond_true = 1'b0;
        case (uw.cond)
            COND_ZERO:   cond_true = (a == '0);
            COND_SIGN:   cond_true = a[0];
            COND_CARRY:  cond_true = cc[0];
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase

        upc_next = upc + 8'd1;
        case (uw.seq)
            SEQ_NEXT:     upc_next = upc + 8'd1;
            SEQ_JUMP:     upc_next = uw.addr;
            SEQ_DISPATCH: upc_next = {1'b1, o};
            SEQ_COND:     upc_next = cond_true ? uw.addr : upc + 8'd1;
            default:      upc_next = upc + 8'd1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            upc <= '0;
            p   <= '0;
            a   <= '0;
            c   <= '0;
            o   <= '0;
            r   <= '0;
            cc  <= '0;
        end else begin
            upc <= upc_next;
            a   <= a_next;
            if (uw.ld_c) begin
                c <= data_in;
            end
            if (uw.ld_or) begin
                o <= c[1:7];
                r <= c[8:11];
            end
            if (uw.p_ld) begin
                p <= c[15:31];
            end else if (uw.p_inc) begin
                p <= p + 17'd1;
            end
            if (uw.cc_ld) begin
                cc <= cc_next;
            end
        end
    end

    // Register file is not reset, but a reset edge must still suppress the write.
    always_ff @(posedge clock) begin
        if (reset && uw.rf_wr) begin
            rf[r] <= a;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: per-scenario microcode and program images, hand-computed results.
module tb_cpu;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [0:31]  data_in;
    logic [15:31] address;

    logic [0:31]  prog [0:1023];
    int unsigned  tests_run    = 0;
    int unsigned  tests_failed = 0;

    // Microword field bits, written out independently of the design package.
    localparam logic [23:0] U_JUMP  = 24'h400000;
    localparam logic [23:0] U_DISP  = 24'h800000;
    localparam logic [23:0] U_COND  = 24'hC00000;
    localparam logic [23:0] U_SIGN  = 24'h100000;
    localparam logic [23:0] U_CARRY = 24'h200000;
    localparam logic [23:0] U_ASEL  = 24'h080000;
    localparam logic [23:0] U_LDC   = 24'h040000;
    localparam logic [23:0] U_LDOR  = 24'h020000;
    localparam logic [23:0] U_PINC  = 24'h010000;
    localparam logic [23:0] U_PLD   = 24'h008000;
    localparam logic [23:0] U_A_RF  = 24'h001000;
    localparam logic [23:0] U_A_C   = 24'h002000;
    localparam logic [23:0] U_A_ADD = 24'h003000;
    localparam logic [23:0] U_A_SUB = 24'h004000;
    localparam logic [23:0] U_A_AND = 24'h005000;
    localparam logic [23:0] U_RFWR  = 24'h000800;
    localparam logic [23:0] U_CCLD  = 24'h000400;
    localparam logic [23:0] U_ENDE  = 24'h000200;

    cpu #(
        .UC_DEPTH(256),
        .UC_WIDTH(24)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data_in(data_in),
        .address(address)
    );

    always #50ns clock = ~clock;

    assign data_in = (address < 17'd1024) ? prog[address[22:31]] : '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 256; i++) dut.uc_rom.memory[i] = '0;
        for (int i = 0; i < 1024; i++) prog[i] = '0;
    endtask

    task automatic uc(input int unsigned at, input logic [23:0] w);
        dut.uc_rom.memory[at] = w;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock);
        #1ns;
    endtask

    task automatic apply_reset(input int unsigned cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clock);
        #1ns;
        reset = 1'b1;
    endtask

    task automatic run_to_wait(input int unsigned budget, output int unsigned ende_cnt,
                               output logic reached);
        int unsigned n = 0;
        ende_cnt = 0;
        while (dut.o != 7'd46 && n < budget) begin
            if (dut.ende) ende_cnt++;
            step(1);
            n++;
        end
        reached = (dut.o == 7'd46);
    endtask

    task automatic run_to_upc(input logic [7:0] target, input int unsigned budget,
                              output logic reached);
        int unsigned n = 0;
        while (dut.upc != target && n < budget) begin
            step(1);
            n++;
        end
        reached = (dut.upc == target);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        logic        ok;

        // Reset dominates a busy microword held at address 0
        clear_all();
        uc(0, U_LDC | U_PINC | U_LDOR | U_A_C | U_JUMP | 24'h05);
        prog[0] = 32'h2E000000;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1ns;
        check_eq("rst_hold_upc", 32'(dut.upc), 32'h0);
        check_eq("rst_hold_p",   32'(dut.p),   32'h0);
        check_eq("rst_hold_c",   dut.c,        32'h0);
        check_eq("rst_hold_a",   dut.a,        32'h0);
        check_eq("rst_hold_o",   32'(dut.o),   32'h0);
        check_eq("rst_hold_cc",  32'(dut.cc),  32'h0);
        reset = 1'b1;
        check_eq("rst_address",  32'(address), 32'h0);
        step(1);
        check_eq("rel_c",   dut.c,        32'h2E000000);
        check_eq("rel_p",   32'(dut.p),   32'h1);
        check_eq("rel_upc", 32'(dut.upc), 32'h05);
        check_eq("rel_a",   dut.a,        32'h0);
        check_eq("rel_o",   32'(dut.o),   32'h0);

        // Fetch / decode / dispatch into the WAIT loop
        clear_all();
        uc(0, U_LDC | U_PINC);
        uc(1, U_LDOR);
        uc(2, U_DISP);
        uc('hAE, U_JUMP | 24'hAE);
        prog[0] = 32'h2E000000;
        apply_reset(1);
        check_eq("s1_address", 32'(address), 32'h0);
        check_eq("s1_upc",     32'(dut.upc), 32'h0);
        check_eq("s1_o",       32'(dut.o),   32'h0);
        step(1);
        check_eq("s2_address", 32'(address), 32'h1);
        check_eq("s2_c",       dut.c,        32'h2E000000);
        step(1);
        check_eq("s2_o",       32'(dut.o),   32'd46);
        step(1);
        check_eq("s2_dispatch", 32'(dut.upc), 32'hAE);
        step(3);
        check_eq("s2_loop_upc", 32'(dut.upc), 32'hAE);
        check_eq("s2_loop_o",   32'(dut.o),   32'd46);

        // Register file load and add with carry out to zero
        clear_all();
        uc(0, U_LDC | U_PINC);
        uc(1, U_LDOR | U_LDC | U_PINC);
        uc(2, U_A_C);
        uc(3, U_RFWR | U_LDC | U_PINC);
        uc(4, U_A_C);
        uc(5, U_A_RF);
        uc(6, U_A_ADD | U_CCLD);
        uc(7, U_COND | 24'h20);
        uc('h20, U_JUMP | 24'h20);
        prog[0] = 32'h00100000;
        prog[1] = 32'h00000005;
        prog[2] = 32'hFFFFFFFB;
        apply_reset(1);
        step(3);
        check_eq("s3_r",     32'(dut.r),   32'h1);
        check_eq("s3_a_c",   dut.a,        32'h5);
        step(1);
        check_eq("s3_rf1",   dut.rf[1],    32'h5);
        check_eq("s3_c",     dut.c,        32'hFFFFFFFB);
        step(1);
        check_eq("s3_a_c2",  dut.a,        32'hFFFFFFFB);
        step(1);
        check_eq("s3_a_rf",  dut.a,        32'h5);
        step(1);
        check_eq("s3_a_add", dut.a,        32'h0);
        check_eq("s3_cc",    32'(dut.cc),  32'h8);
        step(1);
        check_eq("s3_zero_jump", 32'(dut.upc), 32'h20);

        // Subtract with borrow, conditional branches, AND flags
        clear_all();
        uc(0, U_LDC | U_PINC);
        uc(1, U_A_C | U_LDC | U_PINC);
        uc(2, U_A_SUB | U_CCLD);
        uc(3, U_COND | U_CARRY | 24'h40);
        uc(4, U_COND | U_SIGN | 24'h30);
        uc('h30, U_A_AND | U_CCLD);
        uc('h31, U_JUMP | 24'h31);
        prog[0] = 32'h00000001;
        prog[1] = 32'h00000002;
        apply_reset(1);
        step(3);
        check_eq("s4_a_sub", dut.a,        32'hFFFFFFFF);
        check_eq("s4_cc",    32'(dut.cc),  32'h1);
        step(1);
        check_eq("s4_carry_not_taken", 32'(dut.upc), 32'h04);
        step(1);
        check_eq("s4_sign_taken",      32'(dut.upc), 32'h30);
        step(1);
        check_eq("s4_a_and", dut.a,        32'h2);
        check_eq("s4_cc_pos", 32'(dut.cc), 32'h2);

        // Program counter wrap, load priority, C-relative addressing
        clear_all();
        uc(0, U_LDC);
        uc(1, U_PLD);
        uc(2, U_PINC);
        uc(3, U_PINC);
        uc(4, U_LDC);
        uc(5, U_PINC | U_PLD);
        uc(6, U_PINC);
        uc(7, U_ASEL | U_LDC);
        uc(8, U_JUMP | 24'h08);
        prog[0]    = 32'h0001FFFF;
        prog[1]    = 32'h00000040;
        prog['h40] = 32'h12345678;
        apply_reset(1);
        step(2);
        check_eq("s5_p_max",   32'(address), 32'h1FFFF);
        step(1);
        check_eq("s5_p_wrap",  32'(dut.p),   32'h0);
        step(2);
        check_eq("s5_c_40",    dut.c,        32'h40);
        step(1);
        check_eq("s5_p_ld_pri", 32'(dut.p),  32'h40);
        step(1);
        check_eq("s5_addr_sel", 32'(address), 32'h40);
        step(1);
        check_eq("s5_c_far",   dut.c,        32'h12345678);

        // Three-instruction program ending in WAIT, then a mid-run reset
        clear_all();
        uc(0, U_LDC | U_PINC);
        uc(1, U_LDOR);
        uc(2, U_DISP);
        uc('h81, U_LDC | U_PINC | U_JUMP | 24'h10);
        uc('h10, U_A_C | U_ENDE | U_JUMP);
        uc('h82, U_LDC | U_PINC | U_JUMP | 24'h11);
        uc('h11, U_A_ADD | U_CCLD | U_ENDE | U_JUMP);
        uc('h83, U_RFWR | U_ENDE | U_JUMP);
        uc('hAE, U_JUMP | 24'hAE);
        prog[0] = 32'h01000000;
        prog[1] = 32'd7;
        prog[2] = 32'h02000000;
        prog[3] = 32'd3;
        prog[4] = 32'h03300000;
        prog[5] = 32'h2E000000;
        apply_reset(1);
        run_to_wait(200, cnt, ok);
        check_eq("s6_wait_reached", 32'(ok), 32'h1);
        check_eq("s6_ende_count",   cnt,     32'd3);
        check_eq("s6_a",     dut.a,       32'd10);
        check_eq("s6_rf3",   dut.rf[3],   32'd10);
        check_eq("s6_cc",    32'(dut.cc), 32'h2);
        check_eq("s6_p",     32'(dut.p),  32'd6);
        step(2);
        check_eq("s6_wait_loop", 32'(dut.upc), 32'hAE);

        prog[1] = 32'd20;
        apply_reset(1);
        run_to_upc(8'h83, 200, ok);
        check_eq("s6_store_reached", 32'(ok), 32'h1);
        check_eq("s6_a_pre_store",   dut.a,   32'd23);
        apply_reset(1);
        check_eq("s6_mid_rst_upc",  32'(dut.upc),  32'h0);
        check_eq("s6_mid_rst_addr", 32'(address),  32'h0);
        check_eq("s6_mid_rst_a",    dut.a,         32'h0);
        check_eq("s6_no_rf_write",  dut.rf[3],     32'd10);
        run_to_wait(200, cnt, ok);
        check_eq("s6_rerun_reached", 32'(ok),   32'h1);
        check_eq("s6_rerun_ende",    cnt,       32'd3);
        check_eq("s6_rerun_rf3",     dut.rf[3], 32'd23);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
